// File: rtl/ps2_keycode_rx_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receive path.
// keyboard_ctl imports the same package, so both sides agree on the codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] KC_STOP  = 8'hF0;
    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_LEFT  = 8'h1C;
    localparam logic [7:0] KC_RIGHT = 8'h23;
    localparam logic [7:0] KC_UP    = 8'h1D;
    localparam logic [7:0] KC_ENTER = 8'h5A;

    // PS/2 frames use odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keycode output bundle from the PS/2 receiver to its consumer.
// master: the receiver drives it; slave: keyboard_ctl (or a monitor) observes it.
interface ps2_keycode_rx_if;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;
    logic        busy;
    logic        filt_clk;

    modport master (
        output keycode,
        output keycode_valid,
        output frame_err,
        output busy,
        output filt_clk
    );

    modport slave (
        input keycode,
        input keycode_valid,
        input frame_err,
        input busy,
        input filt_clk
    );
endinterface

// File: rtl/ps2_keycode_rx_sync_filter.sv
// Brings the asynchronous PS/2 pins into the clk domain and debounces ps2_clk.
// The filtered clock only changes after the synchronised pin has disagreed with
// it for FILTER_LEN consecutive cycles; fall marks its high-to-low transition.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic filt_clk,
    output logic sync_data,
    output logic fall
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {ps2_data, ps2_clk};

    // One 2-FF synchroniser per pin; both idle high, matching the bus idle level.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;

        // Two-stage capture of the raw pin.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_reg <= 1'b1;
                sync_reg <= 1'b1;
            end else begin
                meta_reg <= pin_raw[gi];
                sync_reg <= meta_reg;
            end
        end

        assign pin_sync[gi] = sync_reg;
    end

    logic [FCW-1:0] filt_cnt_reg;
    logic           filt_clk_reg;
    logic           filt_clk_d_reg;

    // Glitch filter: count disagreement cycles, flip the level on the FILTER_LEN-th.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_reg   <= '0;
            filt_clk_reg   <= 1'b1;
            filt_clk_d_reg <= 1'b1;
        end else begin
            filt_clk_d_reg <= filt_clk_reg;
            if (pin_sync[0] != filt_clk_reg) begin
                if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
                    filt_clk_reg <= pin_sync[0];
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + FCW'(1);
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    assign filt_clk  = filt_clk_reg;
    assign sync_data = pin_sync[1];
    assign fall      = filt_clk_d_reg & ~filt_clk_reg;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver. Decodes 11-bit frames (start, 8 data LSB-first,
// odd parity, stop) and keeps a two-byte history {previous, latest} so that a
// release code arrives as e.g. 16'hF01C. Receive only; never drives the pins.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    ps2_keycode_rx_if.master kc_if
);

    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    logic filt_clk;
    logic sync_data;
    logic fall;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .filt_clk  (filt_clk),
        .sync_data (sync_data),
        .fall      (fall)
    );

    rx_state_t        state_reg,    state_next;
    logic [2:0]       bit_cnt_reg,  bit_cnt_next;
    logic [7:0]       sh_reg,       sh_next;
    logic             parity_reg,   parity_next;
    logic [TMO_W-1:0] tmo_cnt_reg,  tmo_cnt_next;
    logic [15:0]      keycode_reg,  keycode_next;
    logic             kv_reg,       kv_next;
    logic             fe_reg,       fe_next;

    // Frame state, shifter, timeout counter and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            sh_reg      <= '0;
            parity_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
            keycode_reg <= '0;
            kv_reg      <= 1'b0;
            fe_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            sh_reg      <= sh_next;
            parity_reg  <= parity_next;
            tmo_cnt_reg <= tmo_cnt_next;
            keycode_reg <= keycode_next;
            kv_reg      <= kv_next;
            fe_reg      <= fe_next;
        end
    end

    // Next-state logic: a filtered falling edge advances the frame; a stalled
    // frame is abandoned once the counter reaches TMO_MAX, unless a fall
    // arrives in that same cycle.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        sh_next      = sh_reg;
        parity_next  = parity_reg;
        tmo_cnt_next = tmo_cnt_reg;
        keycode_next = keycode_reg;
        kv_next      = 1'b0;
        fe_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                tmo_cnt_next = '0;
                if (fall) begin
                    if (!sync_data) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        fe_next = 1'b1;
                    end
                end
            end

            default: begin
                if (fall) begin
                    tmo_cnt_next = '0;
                    case (state_reg)
                        DATA: begin
                            sh_next      = {sync_data, sh_reg[7:1]};
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_next = PARITY;
                            end
                        end
                        PARITY: begin
                            parity_next = sync_data;
                            state_next  = STOP;
                        end
                        STOP: begin
                            if (sync_data && odd_parity_ok(sh_reg, parity_reg)) begin
                                keycode_next = {keycode_reg[7:0], sh_reg};
                                kv_next      = 1'b1;
                            end else begin
                                fe_next = 1'b1;
                            end
                            state_next = IDLE;
                        end
                        default: begin
                            state_next = IDLE;
                        end
                    endcase
                end else if (tmo_cnt_reg == TMO_MAX) begin
                    fe_next      = 1'b1;
                    state_next   = IDLE;
                    tmo_cnt_next = '0;
                    bit_cnt_next = '0;
                    sh_next      = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
        endcase
    end

    assign kc_if.keycode       = keycode_reg;
    assign kc_if.keycode_valid = kv_reg;
    assign kc_if.frame_err     = fe_reg;
    assign kc_if.busy          = (state_reg != IDLE);
    assign kc_if.filt_clk      = filt_clk;

endmodule
